// File: rtl/permute_pkg.sv
// Shared encodings for the tile permutation engine: reshape modes, FSM states
// and the per-cell pass select.
package permute_pkg;

    localparam logic [1:0] MODE_ROW    = 2'd0;
    localparam logic [1:0] MODE_COL    = 2'd1;
    localparam logic [1:0] MODE_TRANS  = 2'd2;
    localparam logic [1:0] MODE_ROWCOL = 2'd3;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SHUF_A = 2'd1,
        ST_SHUF_B = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        PASS_ROW   = 2'd0,
        PASS_COL   = 2'd1,
        PASS_TRANS = 2'd2,
        PASS_HOLD  = 2'd3
    } pass_t;

    // ROWCOL starts with the row pass; its column pass follows in SHUF_B.
    function automatic pass_t first_pass(input logic [1:0] mode);
        case (mode)
            MODE_COL:   return PASS_COL;
            MODE_TRANS: return PASS_TRANS;
            default:    return PASS_ROW;
        endcase
    endfunction

endpackage

// File: rtl/permute_tile_if.sv
// Row stream in, row stream out. Handshake: a beat transfers on a rising clk
// edge where valid && ready; valid never waits on ready, data is held while stalled.
interface permute_tile_if
    import permute_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N     = 8,
    parameter int LOGN  = $clog2(N)
);
    logic                in_valid;
    logic                in_ready;
    logic [N*WIDTH-1:0]  in_data;
    logic [1:0]          mode;
    logic [N*LOGN-1:0]   row_perm;
    logic [N*LOGN-1:0]   col_perm;
    logic                out_valid;
    logic                out_ready;
    logic [N*WIDTH-1:0]  out_data;
    logic                out_last;
    logic                busy;

    modport master (
        output in_valid, in_data, mode, row_perm, col_perm, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy
    );

    modport slave (
        input  in_valid, in_data, mode, row_perm, col_perm, out_ready,
        output in_ready, out_valid, out_data, out_last, busy
    );
endinterface

// File: rtl/permute_tile_cell.sv
// One tile element: loaded from the input row during LOAD, or from one of three
// shuffle sources (row, column, transpose) during a shuffle pass.
module permute_tile_cell
    import permute_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N     = 8,
    parameter int LOGN  = $clog2(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ld_en,
    input  logic [WIDTH-1:0]   ld_data,
    input  logic               sh_en,
    input  pass_t              pass_sel,
    input  logic [N*WIDTH-1:0] row_src,
    input  logic [LOGN-1:0]    row_sel,
    input  logic [N*WIDTH-1:0] col_src,
    input  logic [LOGN-1:0]    col_sel,
    input  logic [WIDTH-1:0]   trans_src,
    output logic [WIDTH-1:0]   q
);

    logic [WIDTH-1:0] shuf_d;

    // row_src is this cell's column across all rows; col_src is its row.
    always_comb begin
        shuf_d = q;
        case (pass_sel)
            PASS_ROW:   shuf_d = row_src[row_sel*WIDTH +: WIDTH];
            PASS_COL:   shuf_d = col_src[col_sel*WIDTH +: WIDTH];
            PASS_TRANS: shuf_d = trans_src;
            default:    shuf_d = q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (ld_en) begin
            q <= ld_data;
        end else if (sh_en) begin
            q <= shuf_d;
        end
    end

endmodule

// File: rtl/permute_tile.sv
// N x N tile permutation engine: load N rows, reshape in one or two passes,
// then drain N rows with back-pressure. Single tile buffer, no load/drain overlap.
module permute_tile
    import permute_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N     = 8,
    parameter int LOGN  = $clog2(N)
) (
    input  logic            clk,
    input  logic            reset,
    permute_tile_if.slave   bus,
    output state_t          dbg_state
);

    localparam logic [LOGN:0] CNT_LAST = (LOGN+1)'(N-1);

    state_t              state_q, state_d;
    logic [LOGN:0]       ld_cnt_q, dr_cnt_q;
    logic [1:0]          mode_q;
    logic [N*LOGN-1:0]   row_perm_q, col_perm_q;

    logic [N*N*WIDTH-1:0] tile_flat;
    logic [N*WIDTH-1:0]   row_vec [N];
    logic [N*WIDTH-1:0]   col_vec [N];

    logic                in_fire, out_fire, sh_en;
    pass_t               pass_sel;

    assign in_fire   = bus.in_valid && bus.in_ready;
    assign out_fire  = bus.out_valid && bus.out_ready;
    assign dbg_state = state_q;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD: begin
                if (in_fire && ld_cnt_q == CNT_LAST) state_d = ST_SHUF_A;
            end
            ST_SHUF_A: begin
                state_d = (mode_q == MODE_ROWCOL) ? ST_SHUF_B : ST_DRAIN;
            end
            ST_SHUF_B: begin
                state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (out_fire && dr_cnt_q == CNT_LAST) state_d = ST_LOAD;
            end
            default: state_d = ST_LOAD;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.in_ready  = (state_q == ST_LOAD);
        bus.out_valid = (state_q == ST_DRAIN);
        sh_en         = 1'b0;
        pass_sel      = PASS_HOLD;
        case (state_q)
            ST_SHUF_A: begin
                sh_en    = 1'b1;
                pass_sel = first_pass(mode_q);
            end
            ST_SHUF_B: begin
                sh_en    = 1'b1;
                pass_sel = PASS_COL;
            end
            default: begin
                sh_en    = 1'b0;
                pass_sel = PASS_HOLD;
            end
        endcase
    end

    // Output row is forced to zero outside DRAIN so idle outputs stay quiet.
    assign bus.out_data = (state_q == ST_DRAIN) ? row_vec[dr_cnt_q[LOGN-1:0]] : '0;
    assign bus.out_last = (state_q == ST_DRAIN) && (dr_cnt_q == CNT_LAST);
    assign bus.busy     = (state_q != ST_LOAD) || (ld_cnt_q != '0);

    // ---------------- counters and config capture ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            ld_cnt_q   <= '0;
            dr_cnt_q   <= '0;
            mode_q     <= MODE_ROW;
            row_perm_q <= '0;
            col_perm_q <= '0;
        end else begin
            if (in_fire) begin
                ld_cnt_q <= (ld_cnt_q == CNT_LAST) ? '0 : ld_cnt_q + 1'b1;
                if (ld_cnt_q == '0) begin
                    mode_q     <= bus.mode;
                    row_perm_q <= bus.row_perm;
                    col_perm_q <= bus.col_perm;
                end
            end
            if (out_fire) begin
                dr_cnt_q <= (dr_cnt_q == CNT_LAST) ? '0 : dr_cnt_q + 1'b1;
            end
        end
    end

    // ---------------- tile views ----------------
    always_comb begin
        for (int r = 0; r < N; r++) begin
            row_vec[r] = tile_flat[r*N*WIDTH +: N*WIDTH];
        end
        for (int c = 0; c < N; c++) begin
            col_vec[c] = '0;
            for (int k = 0; k < N; k++) begin
                col_vec[c][k*WIDTH +: WIDTH] = tile_flat[(k*N+c)*WIDTH +: WIDTH];
            end
        end
    end

    // ---------------- cell array ----------------
    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            logic [WIDTH-1:0] cell_q;

            permute_tile_cell #(
                .WIDTH (WIDTH),
                .N     (N),
                .LOGN  (LOGN)
            ) u_cell (
                .clk       (clk),
                .reset     (reset),
                .ld_en     (in_fire && (ld_cnt_q[LOGN-1:0] == LOGN'(r))),
                .ld_data   (bus.in_data[c*WIDTH +: WIDTH]),
                .sh_en     (sh_en),
                .pass_sel  (pass_sel),
                .row_src   (col_vec[c]),
                .row_sel   (row_perm_q[r*LOGN +: LOGN]),
                .col_src   (row_vec[r]),
                .col_sel   (col_perm_q[c*LOGN +: LOGN]),
                .trans_src (tile_flat[(c*N+r)*WIDTH +: WIDTH]),
                .q         (cell_q)
            );

            assign tile_flat[(r*N+c)*WIDTH +: WIDTH] = cell_q;
        end
    end

endmodule

// File: tb/tb_permute_tile.sv
// Directed bench for permute_tile: all four modes, latency, back-pressure,
// ignored mid-load config, reset mid-drain, and an N=4/WIDTH=8 transpose.
module tb_permute_tile;
    import permute_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    permute_tile_if #(.WIDTH(16), .N(8)) bus8();
    permute_tile_if #(.WIDTH(8),  .N(4)) bus4();
    state_t st8, st4;

    permute_tile #(.WIDTH(16), .N(8)) dut8 (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus8.slave),
        .dbg_state (st8)
    );

    permute_tile #(.WIDTH(8), .N(4)) dut4 (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus4.slave),
        .dbg_state (st4)
    );

    int pass_cnt = 0;
    int chk_cnt  = 0;
    logic [1:0]   cur_mode;
    int           cur_rp [8];
    int           cur_cp [8];
    logic [127:0] got_rows [8];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference: in[r][c] = r*16 + c, reshaped by the current mode/perms.
    function automatic logic [127:0] exp_row(input int r);
        logic [127:0] v;
        int sr, sc;
        v = '0;
        for (int c = 0; c < 8; c++) begin
            sr = r;
            sc = c;
            case (cur_mode)
                MODE_ROW:    begin sr = cur_rp[r]; sc = c;         end
                MODE_COL:    begin sr = r;         sc = cur_cp[c]; end
                MODE_TRANS:  begin sr = c;         sc = r;         end
                default:     begin sr = cur_rp[r]; sc = cur_cp[c]; end
            endcase
            v[c*16 +: 16] = 16'(sr*16 + sc);
        end
        return v;
    endfunction

    task automatic load_tile(input bit scramble);
        int waitc;
        for (int r = 0; r < 8; r++) begin
            waitc = 0;
            while (!bus8.in_ready && waitc < 20) begin
                @(negedge clk);
                waitc++;
            end
            check("load_in_ready", bus8.in_ready, 1'b1);
            if (r == 0) check("busy_idle", bus8.busy, 1'b0);
            if (r == 1) check("busy_rise", bus8.busy, 1'b1);
            bus8.in_valid = 1'b1;
            for (int c = 0; c < 8; c++) bus8.in_data[c*16 +: 16] = 16'(r*16 + c);
            if (r == 0 || !scramble) begin
                bus8.mode = cur_mode;
                for (int i = 0; i < 8; i++) begin
                    bus8.row_perm[i*3 +: 3] = 3'(cur_rp[i]);
                    bus8.col_perm[i*3 +: 3] = 3'(cur_cp[i]);
                end
            end else begin
                bus8.mode     = ~cur_mode;
                bus8.row_perm = 24'($urandom);
                bus8.col_perm = 24'($urandom);
            end
            @(negedge clk);
        end
        bus8.in_valid = 1'b0;
    endtask

    // Sample 1 follows the accepting edge; out_valid must first be seen at sample exp_lat.
    task automatic check_latency(input int exp_lat);
        int lat;
        lat = 1;
        check("shuf_in_ready", bus8.in_ready, 1'b0);
        while (!bus8.out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, exp_lat);
    endtask

    task automatic drain(input bit rnd, input int rows);
        int got;
        int cyc;
        logic rdy;
        got = 0;
        cyc = 0;
        while (got < rows && cyc < 300) begin
            check("drain_valid", bus8.out_valid, 1'b1);
            check("out_data", bus8.out_data, exp_row(got));
            check("out_last", bus8.out_last, got == 7);
            rdy = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus8.out_ready = rdy;
            if (rdy && bus8.out_valid) begin
                got_rows[got] = bus8.out_data;
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        bus8.out_ready = 1'b0;
        check("drain_count", got, rows);
        if (rows == 8) begin
            check("busy_fall", bus8.busy, 1'b0);
            check("reload_in_ready", bus8.in_ready, 1'b1);
            check("post_out_valid", bus8.out_valid, 1'b0);
        end
    endtask

    initial begin
        logic [31:0] exp4;
        int w;

        bus8.in_valid = 0; bus8.in_data = '0; bus8.mode = '0;
        bus8.row_perm = '0; bus8.col_perm = '0; bus8.out_ready = 0;
        bus4.in_valid = 0; bus4.in_data = '0; bus4.mode = '0;
        bus4.row_perm = '0; bus4.col_perm = '0; bus4.out_ready = 0;

        // reset state
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", bus8.in_ready, 1'b1);
        check("rst_out_valid", bus8.out_valid, 1'b0);
        check("rst_out_last", bus8.out_last, 1'b0);
        check("rst_busy", bus8.busy, 1'b0);
        check("rst_out_data", bus8.out_data, '0);
        check("rst_state", st8, ST_LOAD);
        check("rst_n4_busy", bus4.busy, 1'b0);

        // ROW, reversed
        cur_mode = MODE_ROW;
        for (int i = 0; i < 8; i++) begin cur_rp[i] = 7 - i; cur_cp[i] = i; end
        load_tile(1'b0);
        check_latency(2);
        drain(1'b0, 8);
        check("row_r0_const", got_rows[0], 128'h0077_0076_0075_0074_0073_0072_0071_0070);

        // COL, pairwise swap
        cur_mode = MODE_COL;
        for (int i = 0; i < 8; i++) cur_cp[i] = i ^ 1;
        load_tile(1'b0);
        check_latency(2);
        drain(1'b0, 8);
        check("col_r3_const", got_rows[3], 128'h0036_0037_0034_0035_0032_0033_0030_0031);

        // TRANS
        cur_mode = MODE_TRANS;
        load_tile(1'b0);
        check_latency(2);
        drain(1'b0, 8);
        check("trans_r2_const", got_rows[2], 128'h0072_0062_0052_0042_0032_0022_0012_0002);

        // ROWCOL, both reversed
        cur_mode = MODE_ROWCOL;
        for (int i = 0; i < 8; i++) begin cur_rp[i] = 7 - i; cur_cp[i] = 7 - i; end
        load_tile(1'b0);
        check_latency(3);
        drain(1'b0, 8);
        check("rowcol_00", got_rows[0][15:0], 16'h0077);
        check("rowcol_77", got_rows[7][127:112], 16'h0000);

        // back-pressure, duplicate indices, config scrambled after first beat
        cur_mode = MODE_ROWCOL;
        cur_rp = '{2, 2, 0, 5, 7, 1, 3, 3};
        cur_cp = '{6, 0, 0, 1, 7, 7, 2, 4};
        load_tile(1'b1);
        check_latency(3);
        drain(1'b1, 8);

        // reset at drain row 4, then a fresh tile
        cur_mode = MODE_ROW;
        for (int i = 0; i < 8; i++) begin cur_rp[i] = 7 - i; cur_cp[i] = i; end
        load_tile(1'b0);
        check_latency(2);
        drain(1'b0, 4);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_out_valid", bus8.out_valid, 1'b0);
        check("midrst_in_ready", bus8.in_ready, 1'b1);
        check("midrst_busy", bus8.busy, 1'b0);
        check("midrst_out_last", bus8.out_last, 1'b0);
        check("midrst_state", st8, ST_LOAD);
        cur_mode = MODE_TRANS;
        load_tile(1'b0);
        check_latency(2);
        drain(1'b1, 8);

        // N=4, WIDTH=8 transpose
        for (int r = 0; r < 4; r++) begin
            bus4.in_valid = 1'b1;
            bus4.mode = MODE_TRANS;
            for (int c = 0; c < 4; c++) bus4.in_data[c*8 +: 8] = 8'(r*16 + c);
            @(negedge clk);
        end
        bus4.in_valid = 1'b0;
        w = 0;
        while (!bus4.out_valid && w < 10) begin
            @(negedge clk);
            w++;
        end
        check("n4_latency", w + 1, 2);
        bus4.out_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) exp4[c*8 +: 8] = 8'(c*16 + r);
            check("n4_data", bus4.out_data, exp4);
            check("n4_last", bus4.out_last, r == 3);
            @(negedge clk);
        end
        bus4.out_ready = 1'b0;
        check("n4_busy_fall", bus4.busy, 1'b0);
        check("n4_in_ready", bus4.in_ready, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/permute_tile.md
# permute_tile

Parametrised N×N tile permutation engine for the bfloat datapath. Accepts an N-row tile one row per beat over a valid/ready stream and applies one of four reshapes to the whole tile: row permutation, column permutation, transpose, or combined row+column permutation. It then streams the result out one row per beat with back-pressure. It generalises the fixed 8×8 row/column permuter: any power-of-two N, a transpose mode, a two-pass combined mode, and handshaked input and output.

## Interface
Parameters:
- WIDTH, 16, element width in bits
- N, 8, tile dimension (rows = columns); power of two, ≥2
- LOGN, $clog2(N), index width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input row valid
- in_ready  out  1  block can accept a row
- in_data  in  N*WIDTH  row; element c at [c*WIDTH +: WIDTH]
- mode  in  2  0=ROW, 1=COL, 2=TRANS, 3=ROWCOL; sampled on first accepted row
- row_perm  in  N*LOGN  entry r at [r*LOGN +: LOGN]; sampled with mode
- col_perm  in  N*LOGN  entry c at [c*LOGN +: LOGN]; sampled with mode
- out_valid  out  1  output row valid
- out_ready  in  1  sink accepts row
- out_data  out  N*WIDTH  output row, same element packing as in_data
- out_last  out  1  marks row N-1 of the tile
- busy  out  1  high from first accepted row until last row drained

## Operation
- Input tile in[r][c], output tile out[r][c]:
  - ROW: out[r][c] = in[row_perm[r]][c]
  - COL: out[r][c] = in[r][col_perm[c]]
  - TRANS: out[r][c] = in[c][r]
  - ROWCOL: out[r][c] = in[row_perm[r]][col_perm[c]]
- Permutation vectors are not required to be bijective. Duplicate indices replicate data; no check is made.
- The state machine has states LOAD, SHUF_A, SHUF_B and DRAIN.
- LOAD:
  - in_ready=1. On each accepted beat, write in_data into tile row ld_cnt, then ld_cnt++.
  - On the beat where ld_cnt==0, capture mode, row_perm and col_perm into config registers.
  - When a beat is accepted with ld_cnt==N-1, go to SHUF_A.
- SHUF_A: one cycle; every cell loads its mux output.
  - ROW and ROWCOL use the row pass; COL uses the column pass; TRANS uses the transpose pass.
  - ROWCOL goes next to SHUF_B; all other modes go to DRAIN.
- SHUF_B (ROWCOL only): one cycle; column pass; then DRAIN.
- DRAIN:
  - out_valid=1; out_data = tile row dr_cnt; out_last = (dr_cnt==N-1).
  - On out_valid&&out_ready, dr_cnt++.
  - On the handshake with dr_cnt==N-1, return to LOAD and clear both counters.
- Counters are LOGN+1 bits wide with no wrap-around. Each counter clears when its phase completes.
- Config inputs are ignored outside the ld_cnt==0 accept beat.
- A single tile buffer is used, so load and drain never overlap.

## Timing
- Reset values:
  - state=LOAD; ld_cnt=dr_cnt=0; all tile cells and config registers =0.
  - in_ready=1, out_valid=0, out_last=0, busy=0, out_data=0.
- Reset asserted mid-load, mid-shuffle or mid-drain returns every register to its reset value on the next edge. The partial tile is discarded.
- in_ready is combinational from state only, with no dependence on in_valid.
- out_valid is combinational from state only, with no dependence on out_ready.
- Latency from the edge accepting row N-1 to out_valid high:
  - 2 cycles for ROW/COL/TRANS (SHUF_A, then DRAIN).
  - 3 cycles for ROWCOL.
- Throughput:
  - N input beats + 1 or 2 shuffle cycles + N output beats, with no stalls.
  - in_ready is 0 from SHUF_A until the edge after the final drain handshake.
- busy:
  - Rises on the edge after the first accepted row.
  - Falls on the edge after the final drain handshake.
- Holding out_ready=0 in DRAIN leaves out_data, out_last and dr_cnt stable indefinitely.

## Structure
- Shared package permute_pkg:
  - mode localparams MODE_ROW/MODE_COL/MODE_TRANS/MODE_ROWCOL
  - state encoding
  - pass-select encoding (PASS_ROW, PASS_COL, PASS_TRANS)
- One sub-module, permute_tile_cell, instanced N×N:
  - WIDTH-bit register with load and shift enables.
  - Three N:1 muxes: row source selected by row_perm[r]; column source selected by col_perm[c]; transpose source wired from cell [c][r].
  - 2-bit pass select.
- Top level holds the FSM, counters, config registers, the row-write decode and the output row mux.

## Test plan
- ROW, N=8: in[r][c]=r*16+c; row_perm reverse (7..0) -> out row 0 = {0x70..0x77}; out_last on beat 8; out_valid 2 cycles after last accept.
- COL: col_perm = {1,0,3,2,5,4,7,6} on the same tile -> out row 3 = {0x31,0x30,0x33,0x32,0x35,0x34,0x37,0x36}.
- TRANS -> out[r][c] = c*16+r. Second check with N=4, WIDTH=8 parametrisation gives the same property.
- ROWCOL with both perms reversed -> out[0][0]=0x77, out[7][7]=0x00; out_valid 3 cycles after last accept.
- Back-pressure:
  - Random out_ready gaps -> data and out_last are held stable while stalled; no row is lost or duplicated.
  - mode/perm changed mid-load -> ignored.
- Reset asserted at drain row 4 -> next cycle out_valid=0, in_ready=1, busy=0. A fresh tile then produces correct output.
